// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// One slice of GPS lookahead groups is resolved per stage.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW  = GROUP * GPS;
  localparam int SWS = (SW < 1) ? 1 : SW;
  localparam int S   = (WIDTH / SWS < 1) ? 1 : WIDTH / SWS;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SWS{1'b1}});

  if (GROUP < 1 || GPS < 1 || WIDTH < 1 ||
      (WIDTH % SWS) != 0) begin : g_bad_cfg
    $fatal(1, "cla_adder_pipe: illegal WIDTH/GROUP/GPS");
  end

  // Returns {carry into slice MSB, slice carry-out, slice sum}.
  // Each group is flat lookahead; groups ripple.
  function automatic logic [SWS+1:0] slice_add(
    input logic [SWS-1:0] x,
    input logic [SWS-1:0] y,
    input logic           ci
  );
    logic [SWS-1:0] g;
    logic [SWS-1:0] p;
    logic [SWS:0]   c;
    logic           t;
    logic           term;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = ci;
    for (int grp = 0; grp < GPS; grp++) begin
      for (int i = 0; i < GROUP; i++) begin
        t = c[grp*GROUP];
        for (int j = 0; j <= i; j++)
          t = t & p[grp*GROUP+j];
        for (int j = 0; j <= i; j++) begin
          term = g[grp*GROUP+j];
          for (int m = j + 1; m <= i; m++)
            term = term & p[grp*GROUP+m];
          t = t | term;
        end
        c[grp*GROUP+i+1] = t;
      end
    end
    return {c[SWS-1], c[SWS], p ^ c[SWS-1:0]};
  endfunction

  logic [WIDTH-1:0] w_q [S];
  logic [WIDTH-1:0] b_q [S];
  logic             c_q [S];
  logic             v_q [S];
  logic             ovf_q;

  logic [WIDTH-1:0] w_d [S];
  logic [WIDTH-1:0] b_d [S];
  logic             c_d [S];
  logic             v_d [S];
  logic             o_d [S];

  logic stall;

  assign stall     = v_q[S-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[S-1];
  assign sum       = w_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q;

  // w carries {unprocessed A bits, finished sum bits}.
  for (genvar k = 0; k < S; k++) begin : g_st
    logic [WIDTH-1:0] opw;
    logic             ci_s;
    logic [SWS+1:0]   r;
    if (k == 0) begin : g_in
      assign opw    = a;
      assign b_d[k] = sub ? ~b : b;
      assign ci_s   = cin ^ sub;
      assign v_d[k] = in_valid;
    end else begin : g_pipe
      assign opw    = w_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign ci_s   = c_q[k-1];
      assign v_d[k] = v_q[k-1];
    end
    assign r = slice_add(opw[k*SWS +: SWS],
                         b_d[k][k*SWS +: SWS],
                         ci_s);
    assign w_d[k] = (opw & ~(SMASK << (k*SWS)))
                  | (WIDTH'(r[SWS-1:0]) << (k*SWS));
    assign c_d[k] = r[SWS];
    assign o_d[k] = r[SWS+1] ^ r[SWS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= 1'b0;
        w_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < S; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          w_q[k] <= w_d[k];
          b_q[k] <= b_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[S-1])
        ovf_q <= o_d[S-1];
    end
  end

endmodule
